// File: rtl/accessory_input_ctrl_if.sv
// Accessory word bus: raw button lines and the CPU read strobe in, accessory word and
// pending-event level out. The master side is the CPU/board, the slave side is the controller.
interface accessory_input_ctrl_if #(
  parameter int NUM_BUTTONS = 8,
  parameter int DATA_WIDTH  = 16
);
  logic [NUM_BUTTONS-1:0] buttonsRaw;
  logic                   readAck;
  logic [DATA_WIDTH-1:0]  accessoryData;
  logic                   eventPending;

  modport master (
    output buttonsRaw, readAck,
    input  accessoryData, eventPending
  );

  modport slave (
    input  buttonsRaw, readAck,
    output accessoryData, eventPending
  );
endinterface

// File: rtl/accessory_input_ctrl.sv
// Accessory word front-end: 2-flop sync, per-line debounce, sticky press flags cleared on CPU read.
// Optional auto-repeat of held buttons is enabled with `define ACCESSORY_REPEAT_EN.
module accessory_input_ctrl #(
  parameter int NUM_BUTTONS     = 8,
  parameter int DATA_WIDTH      = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic                  clk,
  input  logic                  reset,
  accessory_input_ctrl_if.slave bus
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (NUM_BUTTONS < 1 || 2 * NUM_BUTTONS > DATA_WIDTH ||
      DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("accessory_input_ctrl: illegal parameter combination");
  end

  logic [NUM_BUTTONS-1:0] s1_q, s1_d;
  logic [NUM_BUTTONS-1:0] s2_q, s2_d;
  logic [NUM_BUTTONS-1:0] stable_q, stable_d;
  logic [NUM_BUTTONS-1:0] flag_q, flag_d;
  logic [NUM_BUTTONS-1:0] arm_q, arm_d;
  logic [CNT_W-1:0]       cnt_q [NUM_BUTTONS];
  logic [CNT_W-1:0]       cnt_d [NUM_BUTTONS];
  logic [1:0]             fill_q, fill_d;
  logic [NUM_BUTTONS-1:0] press;
  logic [NUM_BUTTONS-1:0] rep_fire;

`ifdef ACCESSORY_REPEAT_EN
  localparam int               REP_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_q [NUM_BUTTONS];
  logic [REP_W-1:0] rep_d [NUM_BUTTONS];

  // The counter sits at 0 while released (which covers the press edge) and wraps on firing.
  always_comb begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      rep_fire[i] = stable_q[i] && (rep_q[i] == REP_LAST);
      rep_d[i]    = (!stable_q[i] || rep_fire[i]) ? '0 : rep_q[i] + REP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BUTTONS; i++) rep_q[i] <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  assign rep_fire = '0;
`endif

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    s1_d     = bus.buttonsRaw;
    s2_d     = s1_q;
    fill_d   = fill_q[1] ? fill_q : fill_q + 2'd1;
    stable_d = stable_q;
    // A line may only report a press once it has been seen low (or stably high) since reset,
    // so lines already held at release settle to 1 silently.
    arm_d    = arm_q | stable_q | ({NUM_BUTTONS{fill_q[1]}} & ~s2_q);
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) stable_d[i] = s2_q[i];
        else                      cnt_d[i]    = cnt_q[i] + CNT_W'(1);
      end
    end
    press  = stable_d & ~stable_q & arm_q;
    // Setting wins over the read clear so a press landing on the read edge is not lost.
    flag_d = press | rep_fire | (bus.readAck ? '0 : flag_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      flag_q   <= '0;
      arm_q    <= '0;
      fill_q   <= '0;
      // NOTE: the counter array is small and in flops, so it is reset like any other state.
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      flag_q   <= flag_d;
      arm_q    <= arm_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.accessoryData = DATA_WIDTH'({flag_q, stable_q});
  assign bus.eventPending  = |flag_q;

endmodule

// File: tb/tb_accessory_input_ctrl.sv
// Self-checking bench for accessory_input_ctrl: directed scenarios with literal expectations
// plus randomized buttons/reads/resets compared every cycle against a behavioural model.
module tb_accessory_input_ctrl;

  localparam int NB  = 8;
  localparam int DW  = 16;
  localparam int DEB = 4;
  localparam int REP = 10;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  accessory_input_ctrl_if #(.NUM_BUTTONS(NB), .DATA_WIDTH(DW)) bus ();

  accessory_input_ctrl #(
    .NUM_BUTTONS    (NB),
    .DATA_WIDTH     (DW),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: raw lines reach the debouncer two edges late; a stable level flips after
  // DEB consecutive disagreeing samples; a rise raises the line's flag if the line has been seen
  // low (or stably high) since reset; held lines re-flag every REP edges when repeat is built in.
  int m_stable[NB], m_run[NB], m_flag[NB], m_armed[NB], m_held[NB], m_p1[NB], m_p2[NB];
  int m_edges;

  initial begin : ref_model
    int synced, rose, fire, armed_next;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_edges = 0;
        for (int i = 0; i < NB; i++) begin
          m_stable[i] = 0; m_run[i] = 0; m_flag[i] = 0; m_armed[i] = 0;
          m_held[i] = 0; m_p1[i] = 0; m_p2[i] = 0;
        end
      end else begin
        for (int i = 0; i < NB; i++) begin
          synced     = m_p2[i];
          armed_next = (m_armed[i] != 0 || m_stable[i] != 0 || (m_edges >= 2 && synced == 0)) ? 1 : 0;
          m_held[i]  = (m_stable[i] != 0) ? m_held[i] + 1 : 0;
`ifdef ACCESSORY_REPEAT_EN
          fire = (m_held[i] > 0 && (m_held[i] % REP) == 0) ? 1 : 0;
`else
          fire = 0;
`endif
          rose = 0;
          if (synced == m_stable[i]) m_run[i] = 0;
          else if (m_run[i] + 1 == DEB) begin
            m_stable[i] = synced;
            m_run[i]    = 0;
            rose        = synced;
          end else m_run[i] = m_run[i] + 1;
          if ((rose != 0 && m_armed[i] != 0) || fire != 0) m_flag[i] = 1;
          else if (bus.readAck) m_flag[i] = 0;
          m_armed[i] = armed_next;
          m_p2[i]    = m_p1[i];
          m_p1[i]    = int'(bus.buttonsRaw[i]);
        end
        if (m_edges < 2) m_edges++;
      end
    end
  end

  function automatic logic [DW-1:0] model_word();
    logic [DW-1:0] w = '0;
    for (int i = 0; i < NB; i++) begin
      w[i]      = (m_stable[i] != 0);
      w[NB + i] = (m_flag[i] != 0);
    end
    return w;
  endfunction

  initial begin : compare
    logic [DW-1:0] w;
    forever begin
      @(negedge clk);
      w = model_word();
      check("model_data", 32'(bus.accessoryData), 32'(w));
      check("model_pending", 32'(bus.eventPending), 32'(|w[2*NB-1:NB]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    bus.readAck = 1'b1;
    step(1);
    bus.readAck = 1'b0;
  endtask

  task automatic expect_word(input string name, input logic [DW-1:0] w, input logic pend);
    check({name, "_data"}, 32'(bus.accessoryData), 32'(w));
    check({name, "_pending"}, 32'(bus.eventPending), 32'(pend));
  endtask

  logic [NB-1:0] bounce_pat;

  initial begin : stimulus
    reset          = 1'b1;
    bus.buttonsRaw = '0;
    bus.readAck    = 1'b0;
    step(3);
    expect_word("reset_idle", 16'h0000, 1'b0);
    reset = 1'b0;
    step(10);
    expect_word("idle", 16'h0000, 1'b0);

    // Reset mid-run with every line held, then release with lines still held.
    bus.buttonsRaw = 8'hFF;
    step(12);
    reset = 1'b1;
    #1;
    expect_word("reset_async", 16'h0000, 1'b0);
    step(2);
    reset = 1'b0;
    step(5);
    expect_word("release_edge5", 16'h0000, 1'b0);
    step(1);
    expect_word("release_edge6", 16'h00FF, 1'b0);
    step(4);
    expect_word("release_no_event", 16'h00FF, 1'b0);

    // Clean press of bit 3.
    bus.buttonsRaw = 8'h00;
    step(10);
    expect_word("all_released", 16'h0000, 1'b0);
    bus.buttonsRaw = 8'h08;
    step(5);
    expect_word("press3_edge5", 16'h0000, 1'b0);
    step(1);
    expect_word("press3_edge6", 16'h0808, 1'b1);
    ack_pulse();
    expect_word("press3_read", 16'h0008, 1'b0);

    // Bounce rejection on bit 0.
    bus.buttonsRaw = 8'h00;
    step(10);
    expect_word("pre_bounce", 16'h0000, 1'b0);
    for (int k = 0; k < 20; k++) begin
      bounce_pat     = (k < 3 || (k >= 5 && k < 8)) ? 8'h01 : 8'h00;
      bus.buttonsRaw = bounce_pat;
      step(1);
      expect_word("bounce", 16'h0000, 1'b0);
    end

    // Read strobe landing on the edge where bit 5 rises while bit 1 is pending.
    bus.buttonsRaw = 8'h02;
    step(6);
    expect_word("press1", 16'h0202, 1'b1);
    bus.buttonsRaw = 8'h22;
    step(5);
    ack_pulse();
    expect_word("collision", 16'h2022, 1'b1);

    // Release and re-press of bit 7.
    bus.buttonsRaw = 8'h00;
    step(6);
    ack_pulse();
    step(4);
    expect_word("collision_cleared", 16'h0000, 1'b0);
    bus.buttonsRaw = 8'h80;
    step(6);
    expect_word("press7", 16'h8080, 1'b1);
    ack_pulse();
    expect_word("press7_read", 16'h0080, 1'b0);
    bus.buttonsRaw = 8'h00;
    step(6);
    expect_word("release7", 16'h0000, 1'b0);
    bus.buttonsRaw = 8'h80;
    step(6);
    expect_word("repress7", 16'h8080, 1'b1);
    bus.buttonsRaw = 8'h00;
    step(6);
    ack_pulse();

    // Held bit 2, cleared right after the press edge.
    bus.buttonsRaw = 8'h04;
    step(6);
    expect_word("press2", 16'h0404, 1'b1);
    ack_pulse();
    expect_word("press2_read", 16'h0004, 1'b0);
`ifdef ACCESSORY_REPEAT_EN
    step(8);
    expect_word("repeat_edge9", 16'h0004, 1'b0);
    step(1);
    expect_word("repeat_edge10", 16'h0404, 1'b1);
    ack_pulse();
    expect_word("repeat_read", 16'h0004, 1'b0);
    step(9);
    expect_word("repeat_edge20", 16'h0404, 1'b1);
`else
    step(20);
    expect_word("no_repeat", 16'h0004, 1'b0);
`endif
    bus.buttonsRaw = 8'h00;
    step(10);
    ack_pulse();

    // Randomized buttons, reads and occasional resets; the compare process checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) bus.buttonsRaw = NB'($urandom);
        else bus.buttonsRaw = bus.buttonsRaw ^ (NB'(1) << $urandom_range(0, NB - 1));
      end
      bus.readAck = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        step($urandom_range(1, 3));
        reset = 1'b0;
      end
      step(1);
    end
    bus.readAck = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
